// File: rtl/mmm_nlp_digit_serial.sv
// mmm_nlp_digit_serial: digit-serial Montgomery multiplier, o_res = a*b*2^(-IDW) mod m
module mmm_nlp_digit_serial #(
  parameter int IDW = 256,
  parameter int RW  = 16,
  parameter int ODW = IDW
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  input  logic [IDW-1:0] i_m,
  input  logic [RW-1:0]  i_mp,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [ODW-1:0] o_res,
  output logic           o_busy
);
  localparam int NDIG = IDW / RW;
  localparam int UW   = IDW + RW + 2;
  localparam int TW   = IDW + 2;
  localparam int CW   = $clog2(NDIG + 1);
  typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;
  state_t          state;
  logic [IDW-1:0]  a_sh, b_r, m_r;
  logic [RW-1:0]   mp_r, q;
  logic [TW-1:0]   t, t_nxt;
  logic [UW-1:0]   u;
  logic [CW-1:0]   cnt;
  // one Montgomery digit step; the shift drops RW low bits that are zero by choice of q
  always_comb begin
    u     = UW'(t) + UW'(a_sh[RW-1:0]) * UW'(b_r);
    q     = u[RW-1:0] * mp_r;
    t_nxt = TW'((u + UW'(q) * UW'(m_r)) >> RW);
  end
  // control FSM with registered handshake outputs; a_sh shifts so the current digit is always at the bottom
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_res   <= '0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
      a_sh    <= '0;
      b_r     <= '0;
      m_r     <= '0;
      mp_r    <= '0;
      t       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a_sh    <= i_a;
          b_r     <= i_b;
          m_r     <= i_m;
          mp_r    <= i_mp;
          t       <= '0;
          cnt     <= '0;
          o_ready <= 1'b0;
          o_busy  <= 1'b1;
          state   <= CALC;
        end
        CALC: begin
          t     <= t_nxt;
          a_sh  <= a_sh >> RW;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(NDIG - 1)) ? SUB : CALC;
        end
        SUB: begin
          o_res   <= ODW'((t >= TW'(m_r)) ? t - TW'(m_r) : t);
          o_valid <= 1'b1;
          state   <= DONE;
        end
        default: if (i_ready) begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mmm_nlp_digit_serial.sv
// tb_mmm_nlp_digit_serial: scoreboard bench for the digit-serial Montgomery multiplier
module tb_mmm_nlp_digit_serial;
  localparam int IDW  = 256;
  localparam int RW   = 16;
  localparam int NDIG = IDW / RW;
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic           i_clk = 0, i_rstn = 0, i_valid = 0, i_ready = 1;
  logic [IDW-1:0] i_a = '0, i_b = '0, i_m = '0;
  logic [RW-1:0]  i_mp = '0;
  logic           o_ready, o_valid, o_busy;
  logic [IDW-1:0] o_res;

  typedef struct {logic [255:0] res; logic [255:0] m;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int rdy_mode = 1;
  logic pv = 0, pr = 0;
  logic [255:0] pres = '0;
  int acc_cyc = 0;

  mmm_nlp_digit_serial #(.IDW(IDW), .RW(RW), .ODW(IDW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_m(i_m), .i_mp(i_mp),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // a*b*R^-1 mod m, with R^-1 built by IDW modular halvings
  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
    logic [511:0] p;
    logic [256:0] x;
    p = (512'(a) * 512'(b)) % 512'(m);
    x = 257'd1;
    for (int i = 0; i < IDW; i++) x = x[0] ? (x + 257'(m)) >> 1 : x >> 1;
    return 256'((p * 512'(x)) % 512'(m));
  endfunction

  function automatic logic [15:0] mp_of(input logic [255:0] m);
    logic [15:0] inv, m0;
    m0 = m[15:0];
    inv = 16'd1;
    for (int i = 0; i < 5; i++) inv = inv * (16'd2 - m0 * inv);
    return -inv;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
    int n;
    exp_t e;
    i_a = a; i_b = b; i_m = m; i_mp = mp_of(m);
    i_valid = 1;
    n = 0;
    while (!o_ready && n < 500) begin @(negedge i_clk); n++; end
    if (n == 500) begin
      checks++; errors++;
      $display("FAIL accept_timeout: o_ready never rose within %0d cycles", n);
      i_valid = 0;
      return;
    end
    e.res = model(a, b, m); e.m = m;
    sb.push_back(e);
    @(posedge i_clk);
    acc_cyc = cyc + 1;
    #1 i_valid = 0;
  endtask

  initial forever begin
    @(posedge i_clk); #1;
    i_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom % 2);
  end

  // monitor: pops expected results on each output handshake and checks hold/handshake rules
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rstn) begin
      chk("busy_vs_ready", {255'd0, o_busy}, {255'd0, ~o_ready});
      if (o_valid) chk("ready_low_while_valid", {255'd0, o_ready}, 256'd0);
      if (pv && !pr) begin
        chk("hold_valid", {255'd0, o_valid}, 256'd1);
        chk("hold_res", o_res, pres);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_result: got %h with nothing expected", o_res);
        end else begin
          e = sb.pop_front();
          chk("result", o_res, e.res);
          chk("fully_reduced", {255'd0, o_res < e.m}, 256'd1);
        end
      end
      pv = o_valid; pr = i_ready; pres = o_res;
    end else pv = 0;
  end

  initial begin
    int n, t0;
    logic [255:0] a, b, m, rm;
    logic [256:0] r;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", {255'd0, o_ready}, 256'd1);
    chk("rst_valid", {255'd0, o_valid}, 256'd0);
    chk("rst_busy", {255'd0, o_busy}, 256'd0);
    chk("rst_res", o_res, 256'd0);
    i_rstn = 1;
    @(negedge i_clk);
    // directed vectors and latency
    r = {1'b1, 256'd0} % {1'b0, P};
    rm = r[255:0];
    send(256'd0, rnd256() % P, P);
    n = 0;
    while (!o_valid && n < 100) begin @(negedge i_clk); n++; end
    chk("latency", 256'(n), 256'(NDIG + 2));
    send(256'd1, 256'd1, P);
    send(P - 1, P - 1, P);
    send(rm, 256'h1234_5678_9abc_def0, P);
    send(rnd256() % P, 256'd1, P);
    send(P - 1, 256'd1, P);
    // random operands under random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 120; i++) send(rnd256() % P, rnd256() % P, P);
    for (int i = 0; i < 40; i++) begin
      m = rnd256() | {1'b1, 255'd0} | 256'd1;
      send(rnd256() % m, rnd256() % m, m);
    end
    // long backpressure with stray i_valid held during the operation
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge i_clk); n++; end
    rdy_mode = 2;
    send(rnd256() % P, rnd256() % P, P);
    i_a = rnd256() % P; i_b = rnd256() % P; i_valid = 1;
    n = 0;
    while (!o_valid && n < 100) begin @(negedge i_clk); n++; end
    chk("bp_valid_seen", {255'd0, o_valid}, 256'd1);
    repeat (20) @(negedge i_clk);
    chk("bp_ready_low", {255'd0, o_ready}, 256'd0);
    i_valid = 0;
    rdy_mode = 1;
    // reset in the middle of CALC
    send(rnd256() % P, rnd256() % P, P);
    repeat (8) @(posedge i_clk);
    #2 i_rstn = 0;
    #1;
    chk("abort_valid", {255'd0, o_valid}, 256'd0);
    chk("abort_res", o_res, 256'd0);
    chk("abort_busy", {255'd0, o_busy}, 256'd0);
    chk("abort_ready", {255'd0, o_ready}, 256'd1);
    void'(sb.pop_back());
    repeat (2) @(negedge i_clk);
    i_rstn = 1;
    @(negedge i_clk);
    chk("post_rst_ready", {255'd0, o_ready}, 256'd1);
    repeat (NDIG + 10) @(negedge i_clk);
    send(rnd256() % P, rnd256() % P, P);
    // back-to-back throughput
    for (int i = 0; i < 6; i++) begin
      t0 = acc_cyc;
      send(rnd256() % P, rnd256() % P, P);
      chk("b2b_period", 256'(acc_cyc - t0), 256'(NDIG + 3));
    end
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge i_clk); n++; end
    chk("drain", 256'(sb.size()), 256'd0);
    repeat (3) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
